// File: rtl/pll_drp_ctrl.sv
// Walks a NUM_REGS-entry table doing DRP read-modify-write with the PLL held in reset, then waits for a fresh lock.
// Outputs are registered (1 cycle after the state decision); each DRP access stalls until DRDY, SEN is ignored unless idle.
// Optional macro PLL_DRP_TIMEOUT_EN bounds every wait by TIMEOUT cycles and adds a sticky ERROR state.
module pll_drp_ctrl #(
    parameter int NUM_REGS = 9,
    parameter int TIMEOUT  = 1023
) (
    input  logic        DCLK,
    input  logic        RST_N,
    input  logic        SEN,
    output logic        SRDY,
    output logic        BUSY,
    output logic        ERR,
    output logic [4:0]  TBL_IDX,
    input  logic [38:0] TBL_ENTRY,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    input  logic        LOCKED,
    output logic        PLL_RST
);
    typedef enum logic [3:0] {
        IDLE, ASSERT_RST, READ, WAIT_R, MODIFY, WRITE, WAIT_W, NEXT, WAIT_LOCK, DONE
`ifdef PLL_DRP_TIMEOUT_EN
        , ERROR
`endif
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [4:0]  tbl_idx_q, tbl_idx_d;
    logic        last_q, last_d;
    logic        lock_low_q, lock_low_d;
    logic [15:0] rd_dat_q, rd_dat_d;
    logic        den_q, den_d, dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        pll_rst_q, pll_rst_d;
    logic        srdy_q, srdy_d, busy_q, busy_d;

    logic [15:0] ent_mask, ent_data;
    assign ent_mask = TBL_ENTRY[31:16];
    assign ent_data = TBL_ENTRY[15:0];

`ifdef PLL_DRP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        last_d     = last_q;
        lock_low_d = lock_low_q;
        rd_dat_d   = rd_dat_q;
        case (state_q)
            IDLE: if (SEN) begin
                tbl_idx_d = '0;
                last_d    = 1'b0;
                state_d   = ASSERT_RST;
            end
            ASSERT_RST: state_d = READ;
            READ:       state_d = WAIT_R;
            WAIT_R: if (DRDY) begin
                rd_dat_d = DO;
                state_d  = MODIFY;
            end
            MODIFY:     state_d = WRITE;
            WRITE:      state_d = WAIT_W;
            // Index advances on entry to NEXT so the new ADDR is already on TBL_ENTRY when READ's DADDR is registered.
            WAIT_W: if (DRDY) begin
                state_d = NEXT;
                if (tbl_idx_q == LAST_IDX) last_d = 1'b1;
                else                       tbl_idx_d = tbl_idx_q + 5'd1;
            end
            NEXT: begin
                lock_low_d = 1'b0;
                state_d    = last_q ? WAIT_LOCK : READ;
            end
            // A stale LOCKED from before the reset must be seen low once before it counts.
            WAIT_LOCK: begin
                if (LOCKED && lock_low_q) state_d = DONE;
                else if (!LOCKED)         lock_low_d = 1'b1;
            end
            DONE:       state_d = IDLE;
`ifdef PLL_DRP_TIMEOUT_EN
            ERROR: if (SEN) begin
                tbl_idx_d = '0;
                last_d    = 1'b0;
                state_d   = ASSERT_RST;
            end
`endif
            default:    state_d = IDLE;
        endcase

`ifdef PLL_DRP_TIMEOUT_EN
        cnt_d = '0;
        if (state_d == state_q && state_q inside {WAIT_R, WAIT_W, WAIT_LOCK}) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = ERROR;
            else                              cnt_d = cnt_q + 1'b1;
        end
        err_d = (state_d == ERROR);
`endif

        den_d     = (state_d == READ) || (state_d == WRITE);
        dwe_d     = (state_d == WRITE);
        daddr_d   = den_d ? TBL_ENTRY[38:32] : 7'd0;
        di_d      = dwe_d ? ((rd_dat_q & ent_mask) | (ent_data & ~ent_mask)) : 16'd0;
        pll_rst_d = !(state_d inside {IDLE, WAIT_LOCK, DONE});
        srdy_d    = (state_d == DONE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            tbl_idx_q  <= '0;
            last_q     <= 1'b0;
            lock_low_q <= 1'b0;
            rd_dat_q   <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            pll_rst_q  <= 1'b1;
            srdy_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            last_q     <= last_d;
            lock_low_q <= lock_low_d;
            rd_dat_q   <= rd_dat_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            pll_rst_q  <= pll_rst_d;
            srdy_q     <= srdy_d;
            busy_q     <= busy_d;
        end
    end

`ifdef PLL_DRP_TIMEOUT_EN
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign TBL_IDX = tbl_idx_q;
    assign DEN     = den_q;
    assign DWE     = dwe_q;
    assign DADDR   = daddr_q;
    assign DI      = di_q;
    assign PLL_RST = pll_rst_q;
    assign SRDY    = srdy_q;
    assign BUSY    = busy_q;
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: DRP slave and PLL lock models, random tables checked against a sequential RMW model.
`timescale 1ns/1ps
module tb_pll_drp_ctrl;
    localparam int NREG = 2;
    localparam int TMO  = 15;

    logic        DCLK = 1'b0, RST_N = 1'b0, SEN = 1'b0, DRDY = 1'b0, LOCKED = 1'b0;
    logic        SRDY, BUSY, ERR, DEN, DWE, PLL_RST;
    logic [4:0]  TBL_IDX;
    logic [38:0] TBL_ENTRY;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO = 16'h0;

    logic [38:0] tbl [NREG];
    logic [15:0] mem [128];
    assign TBL_ENTRY = (TBL_IDX < 5'(NREG)) ? tbl[TBL_IDX[0]] : 39'h0;

    int chk_cnt = 0, pass_cnt = 0;
    int den_cnt, ovl_cnt, quiet_viol, rst_viol, srdy_cnt;
    logic [6:0]  wq_a [$];
    logic [15:0] wq_d [$];
    logic [6:0]  exp_a [$];
    logic [15:0] exp_d [$];
    int lat = 2;
    bit drdy_en = 1'b1;
    bit lock_stuck = 1'b0;

    pll_drp_ctrl #(.NUM_REGS(NREG), .TIMEOUT(TMO)) dut (
        .DCLK(DCLK), .RST_N(RST_N), .SEN(SEN), .SRDY(SRDY), .BUSY(BUSY), .ERR(ERR),
        .TBL_IDX(TBL_IDX), .TBL_ENTRY(TBL_ENTRY), .DADDR(DADDR), .DEN(DEN), .DWE(DWE),
        .DI(DI), .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .PLL_RST(PLL_RST)
    );

    always #5 DCLK = ~DCLK;

    // DRP slave: answers each DEN after lat cycles, records writes, flags protocol violations.
    initial begin : responder
        int pend;
        bit pend_rd;
        logic [6:0] rd_a;
        pend = 0; pend_rd = 1'b0; rd_a = '0;
        forever begin
            @(negedge DCLK);
            DRDY = 1'b0;
            if (!RST_N) pend = 0;
            else begin
                if (pend > 0 && drdy_en) begin
                    pend--;
                    if (pend == 0) begin
                        DRDY = 1'b1;
                        DO = pend_rd ? mem[rd_a] : 16'h0;
                    end
                end
                if (DEN) begin
                    den_cnt++;
                    if (pend > 0) ovl_cnt++;
                    if (!PLL_RST) rst_viol++;
                    if (DWE) begin
                        mem[DADDR] = DI;
                        wq_a.push_back(DADDR);
                        wq_d.push_back(DI);
                    end else rd_a = DADDR;
                    pend_rd = !DWE;
                    pend = lat;
                end
            end
            if (!DEN && (DWE || DADDR != 7'd0 || DI != 16'd0)) quiet_viol++;
            if (SRDY) srdy_cnt++;
        end
    end

    // PLL model: unlocked while in reset, locks 5 cycles after release.
    initial begin : lock_model
        int lock_ctr;
        lock_ctr = 0;
        forever begin
            @(negedge DCLK);
            if (lock_stuck) begin LOCKED = 1'b1; lock_ctr = 0; end
            else if (PLL_RST || !RST_N) begin LOCKED = 1'b0; lock_ctr = 0; end
            else if (lock_ctr < 4) begin lock_ctr++; LOCKED = 1'b0; end
            else LOCKED = 1'b1;
        end
    end

    task automatic tick(); @(negedge DCLK); #1; endtask
    task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask

    task automatic clear_mon();
        den_cnt = 0; ovl_cnt = 0; quiet_viol = 0; rst_viol = 0; srdy_cnt = 0;
        wq_a.delete(); wq_d.delete();
    endtask

    task automatic start_seq(); SEN = 1'b1; tick(); SEN = 1'b0; endtask

    task automatic wait_srdy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin tick(); if (SRDY) ok = 1'b1; end
    endtask

    task automatic wait_lock_phase(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin tick(); if (BUSY && !PLL_RST) ok = 1'b1; end
    endtask

    task automatic rand_setup();
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < NREG; i++) tbl[i] = {7'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    // Reference: entries applied in order; each write keeps DO bits where MASK=1, takes DATA elsewhere.
    task automatic model_seq();
        logic [15:0] m [128];
        logic [6:0] a;
        logic [15:0] k, d, nv;
        m = mem;
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < NREG; i++) begin
            a = tbl[i][38:32]; k = tbl[i][31:16]; d = tbl[i][15:0];
            nv = (m[a] & k) | (d & ~k);
            m[a] = nv;
            exp_a.push_back(a); exp_d.push_back(nv);
        end
    endtask

    task automatic test_reset();
        logic [33:0] got;
        ticks(3);
        got = {PLL_RST, DEN, DWE, DADDR, DI, TBL_IDX, SRDY, BUSY, ERR};
        chk_cnt++; if (got !== {1'b1, 33'h0}) $display("FAIL reset_vals: got %h want %h", got, {1'b1, 33'h0}); else pass_cnt++;
        RST_N = 1'b1;
        tick();
        chk_cnt++; if (PLL_RST !== 1'b0) $display("FAIL reset_release_pll_rst: got %b want 0", PLL_RST); else pass_cnt++;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", BUSY); else pass_cnt++;
    endtask

    task automatic test_directed();
        bit ok;
        logic [6:0]  ea [2] = '{7'h08, 7'h14};
        logic [15:0] ed [2] = '{16'h1041, 16'h1208};
        tbl[0] = {7'h08, 16'h1000, 16'h0041};
        tbl[1] = {7'h14, 16'hF000, 16'h0208};
        mem[8'h08] = 16'hFFFF; mem[8'h14] = 16'h1234;
        lat = 2; clear_mon(); start_seq();
        wait_lock_phase(300, ok);
        chk_cnt++; if (!ok) $display("FAIL dir_reach_lock: got timeout want PLL_RST low"); else pass_cnt++;
        chk_cnt++; if (wq_a.size() !== 2) $display("FAIL dir_write_count: got %0d want 2", wq_a.size()); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            chk_cnt++; if ((i < wq_a.size() ? wq_a[i] : 7'bx) !== ea[i]) $display("FAIL dir_waddr%0d: got %h want %h", i, (i < wq_a.size() ? wq_a[i] : 7'bx), ea[i]); else pass_cnt++;
            chk_cnt++; if ((i < wq_d.size() ? wq_d[i] : 16'bx) !== ed[i]) $display("FAIL dir_wdata%0d: got %h want %h", i, (i < wq_d.size() ? wq_d[i] : 16'bx), ed[i]); else pass_cnt++;
        end
        chk_cnt++; if (srdy_cnt !== 0) $display("FAIL dir_srdy_early: got %0d want 0", srdy_cnt); else pass_cnt++;
        chk_cnt++; if (rst_viol !== 0) $display("FAIL dir_pll_rst_during_drp: got %0d want 0", rst_viol); else pass_cnt++;
        wait_srdy(100, ok);
        chk_cnt++; if (!ok) $display("FAIL dir_srdy: got timeout want SRDY"); else pass_cnt++;
        chk_cnt++; if (LOCKED !== 1'b1) $display("FAIL dir_srdy_after_lock: got LOCKED=%b want 1", LOCKED); else pass_cnt++;
        tick();
        chk_cnt++; if ({SRDY, BUSY} !== 2'b00) $display("FAIL dir_idle_after: got %b want 00", {SRDY, BUSY}); else pass_cnt++;
        chk_cnt++; if (den_cnt !== 4) $display("FAIL dir_den_count: got %0d want 4", den_cnt); else pass_cnt++;
    endtask

    task automatic run_random(input string tag, input int l);
        bit ok;
        rand_setup(); model_seq();
        lat = l; clear_mon(); start_seq();
        wait_srdy(400, ok);
        chk_cnt++; if (!ok) $display("FAIL %s_srdy: got timeout want SRDY", tag); else pass_cnt++;
        chk_cnt++; if (wq_a.size() !== NREG) $display("FAIL %s_write_count: got %0d want %0d", tag, wq_a.size(), NREG); else pass_cnt++;
        for (int i = 0; i < NREG; i++) begin
            chk_cnt++;
            if ((i < wq_a.size() ? {wq_a[i], wq_d[i]} : 23'bx) !== {exp_a[i], exp_d[i]})
                $display("FAIL %s_write%0d: got %h want %h", tag, i, (i < wq_a.size() ? {wq_a[i], wq_d[i]} : 23'bx), {exp_a[i], exp_d[i]});
            else pass_cnt++;
        end
        chk_cnt++; if (den_cnt !== 2 * NREG) $display("FAIL %s_den_count: got %0d want %0d", tag, den_cnt, 2 * NREG); else pass_cnt++;
        chk_cnt++; if (ovl_cnt !== 0) $display("FAIL %s_den_overlap: got %0d want 0", tag, ovl_cnt); else pass_cnt++;
        chk_cnt++; if (quiet_viol !== 0) $display("FAIL %s_bus_quiet: got %0d want 0", tag, quiet_viol); else pass_cnt++;
        ticks(2);
    endtask

    task automatic test_min_turnaround(); run_random("turn1", 1); endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) run_random($sformatf("rand%0d", n), int'($urandom_range(1, 3)));
    endtask

    task automatic test_sen_ignored();
        bit ok, arm_w, w_done;
        rand_setup(); lat = 2; clear_mon(); start_seq();
        ok = 1'b0; arm_w = 1'b0; w_done = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            SEN = 1'b0;
            if (arm_w) begin SEN = 1'b1; arm_w = 1'b0; end
            if (!w_done && DEN && DWE) begin arm_w = 1'b1; w_done = 1'b1; end
            if (SRDY) begin ok = 1'b1; SEN = 1'b1; end
        end
        tick(); SEN = 1'b0;
        ticks(40);
        chk_cnt++; if (!ok) $display("FAIL sen_ign_srdy: got timeout want SRDY"); else pass_cnt++;
        chk_cnt++; if (srdy_cnt !== 1) $display("FAIL sen_ign_srdy_count: got %0d want 1", srdy_cnt); else pass_cnt++;
        chk_cnt++; if (den_cnt !== 2 * NREG) $display("FAIL sen_ign_den_count: got %0d want %0d", den_cnt, 2 * NREG); else pass_cnt++;
        chk_cnt++; if (BUSY !== 1'b0) $display("FAIL sen_ign_busy: got %b want 0", BUSY); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int snap;
        logic [33:0] got;
        rand_setup(); lat = 2; clear_mon(); start_seq();
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin tick(); if (DEN && DWE && wq_a.size() == 2) ok = 1'b1; end
        chk_cnt++; if (!ok) $display("FAIL rstmid_second_write: got timeout want WRITE"); else pass_cnt++;
        RST_N = 1'b0;
        #1;
        got = {PLL_RST, DEN, DWE, DADDR, DI, TBL_IDX, SRDY, BUSY, ERR};
        chk_cnt++; if (got !== {1'b1, 33'h0}) $display("FAIL rstmid_vals: got %h want %h", got, {1'b1, 33'h0}); else pass_cnt++;
        snap = den_cnt;
        ticks(3); RST_N = 1'b1; ticks(40);
        chk_cnt++; if (den_cnt !== snap) $display("FAIL rstmid_no_den: got %0d want %0d", den_cnt, snap); else pass_cnt++;
        chk_cnt++; if ({BUSY, PLL_RST} !== 2'b00) $display("FAIL rstmid_idle: got %b want 00", {BUSY, PLL_RST}); else pass_cnt++;
        start_seq(); wait_srdy(400, ok);
        chk_cnt++; if (!ok) $display("FAIL rstmid_restart: got timeout want SRDY"); else pass_cnt++;
        ticks(2);
    endtask

    task automatic test_locked_stuck();
        bit ok;
        rand_setup(); lat = 2; lock_stuck = 1'b1; clear_mon(); start_seq();
        wait_lock_phase(300, ok);
        chk_cnt++; if (!ok) $display("FAIL stuck_reach_lock: got timeout want PLL_RST low"); else pass_cnt++;
        ticks(50);
        chk_cnt++; if (srdy_cnt !== 0) $display("FAIL stuck_no_srdy: got %0d want 0", srdy_cnt); else pass_cnt++;
        chk_cnt++; if ({BUSY, PLL_RST} !== 2'b10) $display("FAIL stuck_waiting: got %b want 10", {BUSY, PLL_RST}); else pass_cnt++;
        lock_stuck = 1'b0;
        wait_srdy(100, ok);
        chk_cnt++; if (!ok) $display("FAIL stuck_release_srdy: got timeout want SRDY"); else pass_cnt++;
        ticks(2);
    endtask

`ifdef PLL_DRP_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        rand_setup(); lat = 2; drdy_en = 1'b0; clear_mon(); start_seq();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin if (DEN) ok = 1'b1; else tick(); end
        chk_cnt++; if (!ok) $display("FAIL tmo_first_read: got timeout want DEN"); else pass_cnt++;
        ticks(TMO);
        chk_cnt++; if (ERR !== 1'b0) $display("FAIL tmo_err_early: got %b want 0", ERR); else pass_cnt++;
        tick();
        chk_cnt++; if ({ERR, PLL_RST, BUSY, DEN} !== 4'b1110) $display("FAIL tmo_error_state: got %b want 1110", {ERR, PLL_RST, BUSY, DEN}); else pass_cnt++;
        drdy_en = 1'b1; ticks(5);
        chk_cnt++; if (ERR !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", ERR); else pass_cnt++;
        start_seq();
        chk_cnt++; if ({ERR, PLL_RST, DEN} !== 3'b010) $display("FAIL tmo_restart: got %b want 010", {ERR, PLL_RST, DEN}); else pass_cnt++;
        tick();
        chk_cnt++; if ({DEN, DWE, DADDR, TBL_IDX} !== {2'b10, tbl[0][38:32], 5'd0}) $display("FAIL tmo_read0: got %h want %h", {DEN, DWE, DADDR, TBL_IDX}, {2'b10, tbl[0][38:32], 5'd0}); else pass_cnt++;
        wait_srdy(400, ok);
        chk_cnt++; if (!ok) $display("FAIL tmo_recover_srdy: got timeout want SRDY"); else pass_cnt++;
        ticks(2);
    endtask
`else
    task automatic test_timeout();
        bit ok;
        rand_setup(); lat = 2; drdy_en = 1'b0; clear_mon(); start_seq();
        ticks(60);
        chk_cnt++; if ({ERR, BUSY, DEN} !== 3'b010) $display("FAIL notmo_waiting: got %b want 010", {ERR, BUSY, DEN}); else pass_cnt++;
        chk_cnt++; if (den_cnt !== 1) $display("FAIL notmo_den_count: got %0d want 1", den_cnt); else pass_cnt++;
        drdy_en = 1'b1;
        wait_srdy(400, ok);
        chk_cnt++; if (!ok) $display("FAIL notmo_resume_srdy: got timeout want SRDY"); else pass_cnt++;
        ticks(2);
    endtask
`endif

    initial begin
        clear_mon();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0;
        for (int i = 0; i < NREG; i++) tbl[i] = 39'h0;
        test_reset();
        test_directed();
        test_min_turnaround();
        test_random();
        test_sen_ignored();
        test_reset_mid();
        test_locked_stuck();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
